muldiv_seq: RTL

- Iterative multiply / divide-modulus unit feeding the ALU's high-byte and low-byte result selects.
- Replaces single-cycle a*b and a/b, a%b with a WIDTH-cycle shift-add multiplier and a restoring divider.
- Holds results in HI/LO registers that the ALU result mux reads directly.
- Handshake is start/busy/done.

---
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and divide/modulus (restoring)
// unit. Results land in hi/lo after WIDTH iterations; start/busy/done handshake.
module muldiv_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic               op_r;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               accept;
    logic               last;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH:0]     rem_s;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     rem_n;
    logic [WIDTH-1:0]   quo_n;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        last    = (cnt == LAST);
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_RUN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One multiply step and one restoring-divide step from current working state
    always_comb begin
        // Upper-half add is W+1 bits so the carry survives the right shift
        mul_sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                         : {1'b0, acc[2*WIDTH-1:WIDTH]};
        acc_n   = {mul_sum, acc[WIDTH-1:1]};

        rem_s   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff    = {1'b0, rem_s} - {2'b00, divisor};
        if (!diff[WIDTH+1]) begin
            rem_n = diff[WIDTH:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_s;
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            op_r        <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            op_r        <= op;
            mcand       <= a;
            acc         <= {{WIDTH{1'b0}}, b};
            divisor     <= b;
            rem         <= '0;
            quo         <= a;
            div_by_zero <= 1'b0;
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            if (op_r) begin
                rem <= rem_n;
                quo <= quo_n;
            end else begin
                acc <= acc_n;
            end
            if (last) begin
                if (op_r) begin
                    hi          <= rem_n[WIDTH-1:0];
                    lo          <= quo_n;
                    div_by_zero <= (divisor == '0);
                end else begin
                    hi <= acc_n[2*WIDTH-1:WIDTH];
                    lo <= acc_n[WIDTH-1:0];
                end
            end
        end
    end

endmodule
